// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense controller: state encoding,
// product price table and coin denominations used for change.
package vend_pkg;

  localparam int unsigned AMT_W      = 8;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned N_PROD     = 4;
  localparam int unsigned N_COIN     = 4;
  localparam int unsigned COIN_IDX_W = 2;

  typedef logic [AMT_W-1:0] amt_t;
  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3,
    ST_CLEAR    = 3'd4
  } state_e;

  localparam amt_t PRICE [N_PROD] = '{8'd50, 8'd75, 8'd100, 8'd120};

  // Largest denomination first so a first-fit scan is greedy.
  localparam amt_t COIN [N_COIN] = '{8'd50, 8'd25, 8'd10, 8'd5};

  function automatic amt_t price_of(input sel_t s);
    return PRICE[s];
  endfunction

endpackage

// File: rtl/vend_coin_splitter.sv
// Greedy coin picker: returns the largest denomination not exceeding the amount,
// or zero when the amount is below the smallest coin.
module vend_coin_splitter
  import vend_pkg::*;
(
  input  amt_t amt_i,
  output amt_t coin_c
);

  always_comb begin
    coin_c = '0;
    for (int unsigned i = 0; i < N_COIN; i++) begin
      if ((coin_c == '0) && (amt_i >= COIN[COIN_IDX_W'(i)])) begin
        coin_c = COIN[COIN_IDX_W'(i)];
      end
    end
  end

endmodule

// File: rtl/vend_dispense.sv
// Vending purchase/refund controller: price check, timed dispense, change, accumulator clear.
// Define CHANGE_COINS_EN to pay change as a greedy 50/25/10/5 coin sequence.
module vend_dispense
  import vend_pkg::*;
#(
  parameter int unsigned DISP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AMT_W-1:0] tot,
  input  logic [SEL_W-1:0] sel,
  input  logic             buy,
  input  logic             cancel,
  output logic             dispense,
  output logic [SEL_W-1:0] prod,
  output logic [AMT_W-1:0] change,
  output logic             change_valid,
  output logic             clr_tot,
  output logic             insufficient,
  output logic             busy
);

  localparam int unsigned CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  amt_t             tot_lat_q, tot_lat_d;
  sel_t             sel_lat_q, sel_lat_d;
  amt_t             rem_q, rem_d;

  logic             dispense_q, dispense_d;
  sel_t             prod_q, prod_d;
  amt_t             change_q, change_d;
  logic             change_valid_q, change_valid_d;
  logic             clr_tot_q, clr_tot_d;
  logic             insufficient_q, insufficient_d;
  logic             busy_q, busy_d;

  amt_t             amt_nxt_c;
  amt_t             coin_c;

  // Amount still owed as seen at the next state: refund, purchase change, or leftover.
  always_comb begin
    amt_nxt_c = '0;
    case (state_q)
      ST_IDLE:     amt_nxt_c = tot;
      ST_DISPENSE: amt_nxt_c = tot_lat_q - price_of(sel_lat_q);
      ST_CHANGE:   amt_nxt_c = rem_q - change_q;
      default:     amt_nxt_c = '0;
    endcase
  end

`ifdef CHANGE_COINS_EN
  vend_coin_splitter u_coin_splitter (
    .amt_i  (amt_nxt_c),
    .coin_c (coin_c)
  );
`else
  // Whole amount paid in one pulse; the leftover in CHANGE is then always zero.
  assign coin_c = amt_nxt_c;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    tot_lat_d      = tot_lat_q;
    sel_lat_d      = sel_lat_q;
    rem_d          = rem_q;
    insufficient_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          rem_d   = amt_nxt_c;
          state_d = (coin_c != '0) ? ST_CHANGE : ST_CLEAR;
        end else if (buy) begin
          tot_lat_d = tot;
          sel_lat_d = sel;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (tot_lat_q < price_of(sel_lat_q)) begin
          insufficient_d = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          state_d = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (cnt_q == CNT_LAST) begin
          rem_d   = amt_nxt_c;
          state_d = (coin_c != '0) ? ST_CHANGE : ST_CLEAR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHANGE: begin
        rem_d   = amt_nxt_c;
        state_d = (coin_c != '0) ? ST_CHANGE : ST_CLEAR;
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs reflect the state being entered so they line up with it after the edge.
    dispense_d     = (state_d == ST_DISPENSE);
    prod_d         = dispense_d ? sel_lat_d : '0;
    change_valid_d = (state_d == ST_CHANGE);
    change_d       = change_valid_d ? coin_c : '0;
    clr_tot_d      = (state_d == ST_CLEAR);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tot_lat_q      <= '0;
      sel_lat_q      <= '0;
      rem_q          <= '0;
      dispense_q     <= 1'b0;
      prod_q         <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      clr_tot_q      <= 1'b0;
      insufficient_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tot_lat_q      <= tot_lat_d;
      sel_lat_q      <= sel_lat_d;
      rem_q          <= rem_d;
      dispense_q     <= dispense_d;
      prod_q         <= prod_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      clr_tot_q      <= clr_tot_d;
      insufficient_q <= insufficient_d;
      busy_q         <= busy_d;
    end
  end

  assign dispense     = dispense_q;
  assign prod         = prod_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign clr_tot      = clr_tot_q;
  assign insufficient = insufficient_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vend_dispense.sv
// Bench for vend_dispense: transaction-level expected-output script plus directed scenarios
// and randomized traffic with occasional asynchronous resets.
module tb_vend_dispense;

  localparam int unsigned DISP = 4;

  logic       clk;
  logic       rst;
  logic [7:0] tot;
  logic [1:0] sel;
  logic       buy;
  logic       cancel;
  logic       dispense;
  logic [1:0] prod;
  logic [7:0] change;
  logic       change_valid;
  logic       clr_tot;
  logic       insufficient;
  logic       busy;

  vend_dispense #(.DISP_CYCLES(DISP)) dut (
    .clk          (clk),
    .rst          (rst),
    .tot          (tot),
    .sel          (sel),
    .buy          (buy),
    .cancel       (cancel),
    .dispense     (dispense),
    .prod         (prod),
    .change       (change),
    .change_valid (change_valid),
    .clr_tot      (clr_tot),
    .insufficient (insufficient),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       disp;
    logic [1:0] prod;
    logic [7:0] chg;
    logic       cv;
    logic       clr;
    logic       ins;
    logic       busy;
  } obs_t;

  int price_tbl [4] = '{50, 75, 100, 120};
  int coin_tbl  [4] = '{50, 25, 10, 5};

  obs_t exp_q [$];
  obs_t cur_exp;
  int   checks = 0;
  int   errors = 0;

  int   disp_total = 0;
  int   disp_rise  = 0;
  int   clr_total  = 0;
  int   ins_total  = 0;
  int   prod_last  = -1;
  int   chg_log [$];
  logic disp_prev  = 1'b0;

  // Change the customer is owed, expressed as the pulses that must appear.
  function automatic void push_change(input int amt);
    obs_t e;
    int   r;
    r = amt;
`ifdef CHANGE_COINS_EN
    foreach (coin_tbl[i]) begin
      while (r >= coin_tbl[i]) begin
        e = '0; e.busy = 1'b1; e.cv = 1'b1; e.chg = 8'(coin_tbl[i]);
        exp_q.push_back(e);
        r -= coin_tbl[i];
      end
    end
`else
    if (r != 0) begin
      e = '0; e.busy = 1'b1; e.cv = 1'b1; e.chg = 8'(r);
      exp_q.push_back(e);
    end
`endif
  endfunction

  function automatic void push_clear();
    obs_t e;
    e = '0; e.busy = 1'b1; e.clr = 1'b1;
    exp_q.push_back(e);
  endfunction

  // Called at each active edge with the inputs the DUT just sampled.
  function automatic void model_edge();
    obs_t e;
    int   price;
    if (!cur_exp.busy && exp_q.size() == 0) begin
      if (cancel) begin
        push_change(int'(tot));
        push_clear();
      end else if (buy) begin
        price = price_tbl[sel];
        e = '0; e.busy = 1'b1;
        exp_q.push_back(e);
        if (int'(tot) < price) begin
          e = '0; e.ins = 1'b1;
          exp_q.push_back(e);
        end else begin
          repeat (DISP) begin
            e = '0; e.busy = 1'b1; e.disp = 1'b1; e.prod = sel;
            exp_q.push_back(e);
          end
          push_change(int'(tot) - price);
          push_clear();
        end
      end
    end
    cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : obs_t'('0);
  endfunction

  task automatic compare(input string name);
    obs_t o;
    o.disp = dispense; o.prod = prod; o.chg = change; o.cv = change_valid;
    o.clr = clr_tot; o.ins = insufficient; o.busy = busy;
    checks++;
    if (o !== cur_exp) begin
      errors++;
      $display("FAIL %s t=%0t got disp=%b prod=%0d chg=%0d cv=%b clr=%b ins=%b busy=%b want disp=%b prod=%0d chg=%0d cv=%b clr=%b ins=%b busy=%b",
               name, $time, o.disp, o.prod, o.chg, o.cv, o.clr, o.ins, o.busy,
               cur_exp.disp, cur_exp.prod, cur_exp.chg, cur_exp.cv, cur_exp.clr, cur_exp.ins, cur_exp.busy);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic chk_chg(input string name, input int start, input int want [$]);
    chk_int({name, "_count"}, chg_log.size() - start, want.size());
    if (chg_log.size() - start == want.size()) begin
      foreach (want[i]) chk_int({name, "_coin"}, chg_log[start + i], want[i]);
    end
  endtask

  // One clock: model update at the edge, compare and record activity just after it.
  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    else begin
      exp_q.delete();
      cur_exp = '0;
    end
    #1;
    compare("cycle");
    if (dispense) begin
      disp_total++;
      prod_last = int'(prod);
    end
    if (dispense && !disp_prev) disp_rise++;
    disp_prev = dispense;
    if (change_valid) chg_log.push_back(int'(change));
    if (clr_tot) clr_total++;
    if (insufficient) ins_total++;
  endtask

  task automatic idle(input int n);
    buy = 1'b0; cancel = 1'b0;
    repeat (n) step();
  endtask

  // Asynchronous reset in mid-cycle: outputs must drop before the next edge.
  task automatic async_reset(input int hold);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    cur_exp = '0;
    compare("rst_async");
    repeat (hold) step();
    rst = 1'b1;
  endtask

  task automatic purchase(input int t, input int s);
    tot = 8'(t); sel = 2'(s); buy = 1'b1; cancel = 1'b0;
    step();
    buy = 1'b0;
  endtask

  int d0, r0, c0, i0, g0;
  int want [$];

  task automatic snap();
    d0 = disp_total; r0 = disp_rise; c0 = clr_total; i0 = ins_total; g0 = chg_log.size();
  endtask

  initial begin
    rst = 1'b1; tot = '0; sel = '0; buy = 1'b0; cancel = 1'b0;
    cur_exp = '0;
    #3 rst = 1'b0;
    repeat (3) step();
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_dispense", int'(dispense), 0);
    rst = 1'b1;
    idle(2);

    // Purchase with change: 100 credit, 75 price.
    snap();
    purchase(100, 1);
    chk_int("buy_latency_check_busy", int'(busy), 1);
    step();
    chk_int("buy_latency_dispense", int'(dispense), 1);
    idle(10);
    chk_int("t1_disp_cycles", disp_total - d0, 4);
    chk_int("t1_prod", prod_last, 1);
    want = '{25};
    chk_chg("t1_change", g0, want);
    chk_int("t1_clr", clr_total - c0, 1);
    chk_int("t1_ins", ins_total - i0, 0);

    // Insufficient credit.
    snap();
    purchase(40, 0);
    idle(6);
    chk_int("t2_ins", ins_total - i0, 1);
    chk_int("t2_disp", disp_total - d0, 0);
    chk_int("t2_clr", clr_total - c0, 0);
    chk_int("t2_busy", int'(busy), 0);

    // Cancel wins over simultaneous buy.
    snap();
    tot = 8'd85; sel = 2'd0; buy = 1'b1; cancel = 1'b1;
    step();
    idle(8);
    chk_int("t3_disp", disp_total - d0, 0);
`ifdef CHANGE_COINS_EN
    want = '{50, 25, 10};
`else
    want = '{85};
`endif
    chk_chg("t3_change", g0, want);
    chk_int("t3_clr", clr_total - c0, 1);

    // Exact payment: no change pulse.
    snap();
    purchase(120, 3);
    idle(10);
    chk_int("t4_disp", disp_total - d0, 4);
    chk_int("t4_prod", prod_last, 3);
    chk_int("t4_change_count", chg_log.size() - g0, 0);
    chk_int("t4_clr", clr_total - c0, 1);

    // Reset on the second dispense clock.
    purchase(100, 2);
    step();
    step();
    chk_int("t5_in_dispense", int'(dispense), 1);
    async_reset(2);
    chk_int("t5_disp_low", int'(dispense), 0);
    snap();
    idle(12);
    chk_int("t5_no_resume", disp_total - d0, 0);
    chk_int("t5_no_clr", clr_total - c0, 0);

    // buy toggling while busy is ignored.
    snap();
    purchase(120, 2);
    for (int k = 1; k <= 7; k++) begin
      buy = k[0];
      step();
    end
    idle(6);
    chk_int("t6_disp", disp_total - d0, 4);
    chk_int("t6_rise", disp_rise - r0, 1);
    chk_int("t6_clr", clr_total - c0, 1);
`ifdef CHANGE_COINS_EN
    want = '{10, 10};
`else
    want = '{20};
`endif
    chk_chg("t6_change", g0, want);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 7))
          0: tot = 8'd0;   1: tot = 8'd40;  2: tot = 8'd50;  3: tot = 8'd75;
          4: tot = 8'd85;  5: tot = 8'd100; 6: tot = 8'd120; default: tot = 8'd255;
        endcase
      end else begin
        tot = 8'($urandom_range(0, 255));
      end
      sel    = 2'($urandom_range(0, 3));
      buy    = ($urandom_range(0, 3) == 0);
      cancel = ($urandom_range(0, 9) == 0);
      step();
      if ($urandom_range(0, 299) == 0) async_reset(2);
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_dispense.md
VEND_DISPENSE -- requirements
Module: vend_dispense

Interface
REQ-001 The block SHALL have parameter DISP_CYCLES, default 4, setting the number of clocks dispense is held high.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port tot, input, 8, credit total from the coin accumulator, unsigned.
REQ-005 The block SHALL have port sel, input, 2, product select, an index into the price table.
REQ-006 The block SHALL have port buy, input, 1, active-high purchase request, level-sampled in IDLE.
REQ-007 The block SHALL have port cancel, input, 1, active-high refund request, level-sampled in IDLE.
REQ-008 The block SHALL have port dispense, output, 1, product release, high for DISP_CYCLES clocks.
REQ-009 The block SHALL have port prod, output, 2, latched sel, valid while dispense=1.
REQ-010 The block SHALL have port change, output, 8, change amount, valid with change_valid.
REQ-011 The block SHALL have port change_valid, output, 1, one-clock change pulse.
REQ-012 The block SHALL have port clr_tot, output, 1, one-clock request to clear the accumulator.
REQ-013 The block SHALL have port insufficient, output, 1, one-clock pulse when credit is below the price.
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, CHECK, DISPENSE, CHANGE and CLEAR.
REQ-016 In IDLE with cancel=1, the FSM SHALL go to CHANGE with amount=tot, and SHALL skip to CLEAR if tot=0.
REQ-017 In IDLE with cancel=0 and buy=1, the FSM SHALL latch tot and sel and go to CHECK; cancel SHALL win over a simultaneous buy.
REQ-018 In CHECK, the FSM SHALL compare latched tot with PRICE[sel]; if tot < price it SHALL pulse insufficient and return to IDLE, otherwise it SHALL go to DISPENSE.
REQ-019 DISPENSE SHALL hold dispense=1 for exactly DISP_CYCLES clocks, counted by an internal counter, and SHALL then go to CHANGE with amount=tot-price.
REQ-020 Subtraction SHALL be 8-bit unsigned and SHALL never underflow, because CHECK guarantees tot >= price.
REQ-021 When amount=0, CHANGE SHALL be skipped and the FSM SHALL go directly to CLEAR.
REQ-022 CLEAR SHALL pulse clr_tot for one clock and then return to IDLE.
REQ-023 buy and cancel SHALL be ignored outside IDLE.
REQ-024 A purchase request SHALL be observable on dispense no later than 2 clocks after buy is sampled.

Reset
REQ-025 rst=0 SHALL immediately force IDLE and drive every output to 0, including during DISPENSE or CHANGE.
REQ-026 A dispense aborted by reset SHALL NOT resume after reset is released.

Configuration
REQ-027 With CHANGE_COINS_EN defined, CHANGE SHALL emit change as a greedy coin sequence of 50, 25, 10 and 5.
- One change_valid pulse per clock; change carries that coin's value.
- Any remainder below 5 SHALL be discarded.
REQ-028 With CHANGE_COINS_EN undefined, CHANGE SHALL last one clock, with change_valid=1 and change=amount.

Structure
REQ-029 The shared package vend_pkg SHALL hold the state encoding, PRICE[0:3]={50,75,100,120} and the coin denominations {50,25,10,5}.
REQ-030 Greedy coin selection SHALL be a sub-module, vend_coin_splitter, instantiated only under CHANGE_COINS_EN.

Verification
REQ-031 The bench SHALL cover: tot=100, sel=1, buy -> dispense high for 4 clocks with prod=1, then change 25, then clr_tot.
- With CHANGE_COINS_EN: a single 25 coin pulse.
REQ-032 The bench SHALL cover: tot=40, sel=0, buy -> insufficient pulse, no dispense, no clr_tot, return to IDLE.
REQ-033 The bench SHALL cover: tot=85, cancel and buy asserted together -> no dispense, then change.
- With CHANGE_COINS_EN: coins 50, 25, 10 on consecutive clocks, then clr_tot.
- Without it: a single change=85 pulse.
REQ-034 The bench SHALL cover: tot=120, sel=3, buy -> dispense for 4 clocks, no change_valid, clr_tot pulse.
REQ-035 The bench SHALL cover: rst=0 on the 2nd clock of dispense -> all outputs 0 at once, IDLE after release, and no dispense without a new buy.
REQ-036 The bench SHALL cover: buy toggled during DISPENSE -> ignored, with exactly one purchase completed.
